// File: rtl/uart_system_pkg.sv
// Shared definitions for the UART system controller: command opcodes,
// receiver-controller state encoding and fixed ALU operand addresses.
package uart_system_pkg;

  localparam logic [7:0] WRITE_CMD          = 8'hAA;
  localparam logic [7:0] READ_CMD           = 8'hBB;
  localparam logic [7:0] ALU_OPERAND_CMD    = 8'hCC;
  localparam logic [7:0] ALU_NO_OPERAND_CMD = 8'hDD;

  localparam int unsigned OPERAND_A_ADDRESS = 0;
  localparam int unsigned OPERAND_B_ADDRESS = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_ADDR   = 3'd1,
    WR_DATA   = 3'd2,
    RD_ADDR   = 3'd3,
    OPERAND_A = 3'd4,
    OPERAND_B = 3'd5,
    ALU_FUNC  = 3'd6
  } state_t;

  function automatic logic state_is_busy(input state_t st);
    return (st != IDLE);
  endfunction

  // States belonging to an ALU command keep the ALU clock running.
  function automatic logic state_gates_clock(input state_t st);
    case (st)
      OPERAND_A, OPERAND_B, ALU_FUNC: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/command_timeout_counter.sv
// Saturating inter-byte idle counter; expired stays high once the limit is reached
// until the next clear.
module command_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);

  logic [COUNT_WIDTH-1:0] count_r;

  // Idle cycle counter, saturating at the limit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (count && (count_r != LIMIT)) begin
      count_r <= count_r + 1'b1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LIMIT);

endmodule

// File: rtl/uart_receiver_controller.sv
// Command sequencer: turns the received UART byte stream into register-file and ALU strobes.
// Define CMD_TIMEOUT_EN to abort commands whose bytes stop arriving for TIMEOUT_CYCLES.
module uart_receiver_controller
  import uart_system_pkg::*;
#(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDRESS_WIDTH      = 4,
  parameter int ALU_FUNCTION_WIDTH = 4
`ifdef CMD_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES     = 65535
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         received_data,
  input  logic                          received_data_valid,
  input  logic                          received_frame_error,
  input  logic                          enable,
  output logic [ADDRESS_WIDTH-1:0]      address,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic                          write_enable,
  output logic                          read_enable,
  output logic [ALU_FUNCTION_WIDTH-1:0] ALU_function,
  output logic                          ALU_enable,
  output logic                          clock_gate_enable,
  output logic                          busy
);

  state_t                   state_r;
  logic [ADDRESS_WIDTH-1:0] addr_latch_r;
  logic                     opcode_accept_s;
  logic                     timeout_expired_s;

  // Only opcodes are gated by enable; the rest of a command always gets through.
  assign opcode_accept_s = received_data_valid && enable && !received_frame_error;

`ifdef CMD_TIMEOUT_EN
  logic timeout_clear_s;
  logic timeout_count_s;

  assign timeout_clear_s = (state_r == IDLE) || received_data_valid;
  assign timeout_count_s = (state_r != IDLE);

  command_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (timeout_clear_s),
    .count   (timeout_count_s),
    .expired (timeout_expired_s)
  );
`else
  assign timeout_expired_s = 1'b0;
`endif

  // Command FSM with registered strobes, datapath outputs and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r           <= IDLE;
      addr_latch_r      <= '0;
      address           <= '0;
      write_data        <= '0;
      ALU_function      <= '0;
      write_enable      <= 1'b0;
      read_enable       <= 1'b0;
      ALU_enable        <= 1'b0;
      clock_gate_enable <= 1'b0;
      busy              <= 1'b0;
    end else begin
      write_enable      <= 1'b0;
      read_enable       <= 1'b0;
      ALU_enable        <= 1'b0;
      busy              <= state_is_busy(state_r);
      clock_gate_enable <= state_gates_clock(state_r);
      if (state_r == IDLE) begin
        if (opcode_accept_s) begin
          case (received_data)
            DATA_WIDTH'(WRITE_CMD): begin
              state_r <= WR_ADDR;
              busy    <= 1'b1;
            end
            DATA_WIDTH'(READ_CMD): begin
              state_r <= RD_ADDR;
              busy    <= 1'b1;
            end
            DATA_WIDTH'(ALU_OPERAND_CMD): begin
              state_r           <= OPERAND_A;
              busy              <= 1'b1;
              clock_gate_enable <= 1'b1;
            end
            DATA_WIDTH'(ALU_NO_OPERAND_CMD): begin
              state_r           <= ALU_FUNC;
              busy              <= 1'b1;
              clock_gate_enable <= 1'b1;
            end
            default: state_r <= IDLE;
          endcase
        end else begin
          state_r <= IDLE;
        end
      end else if (received_data_valid && received_frame_error) begin
        state_r           <= IDLE;
        busy              <= 1'b0;
        clock_gate_enable <= 1'b0;
      end else if (received_data_valid) begin
        case (state_r)
          WR_ADDR: begin
            addr_latch_r <= received_data[ADDRESS_WIDTH-1:0];
            state_r      <= WR_DATA;
          end
          WR_DATA: begin
            write_enable <= 1'b1;
            address      <= addr_latch_r;
            write_data   <= received_data;
            state_r      <= IDLE;
            busy         <= 1'b0;
          end
          RD_ADDR: begin
            read_enable <= 1'b1;
            address     <= received_data[ADDRESS_WIDTH-1:0];
            state_r     <= IDLE;
            busy        <= 1'b0;
          end
          OPERAND_A: begin
            write_enable <= 1'b1;
            address      <= ADDRESS_WIDTH'(OPERAND_A_ADDRESS);
            write_data   <= received_data;
            state_r      <= OPERAND_B;
          end
          OPERAND_B: begin
            write_enable <= 1'b1;
            address      <= ADDRESS_WIDTH'(OPERAND_B_ADDRESS);
            write_data   <= received_data;
            state_r      <= ALU_FUNC;
          end
          ALU_FUNC: begin
            // Clock gate stays open through the start strobe itself.
            ALU_enable        <= 1'b1;
            ALU_function      <= received_data[ALU_FUNCTION_WIDTH-1:0];
            state_r           <= IDLE;
            busy              <= 1'b0;
            clock_gate_enable <= 1'b1;
          end
          default: begin
            state_r           <= IDLE;
            busy              <= 1'b0;
            clock_gate_enable <= 1'b0;
          end
        endcase
      end else if (timeout_expired_s) begin
        state_r           <= IDLE;
        busy              <= 1'b0;
        clock_gate_enable <= 1'b0;
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule
